// File: rtl/grid_game_ctrl_pkg.sv
// grid_game_ctrl_pkg
// Shared definitions for the grid game sequencer: grid size, two-bit cell
// codes as held in the cell array, and the phase codes reported on the
// controller's phase output.
package grid_game_ctrl_pkg;

  localparam int GRID = 4;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_SHIP  = 2'b01;
  localparam logic [1:0] CELL_MISS  = 2'b10;
  localparam logic [1:0] CELL_HIT   = 2'b11;

  localparam logic [2:0] PH_IDLE  = 3'd0;
  localparam logic [2:0] PH_PLACE = 3'd1;
  localparam logic [2:0] PH_FIRE  = 3'd2;
  localparam logic [2:0] PH_WAIT  = 3'd3;
  localparam logic [2:0] PH_CHECK = 3'd4;
  localparam logic [2:0] PH_DONE  = 3'd5;

endpackage

// File: rtl/grid_game_ctrl_if.sv
// grid_game_ctrl_if
// Bundles the signals between the game controller and its surroundings
// (debounced inputs, the cell array and the status display).
//   fire_pulse, row_req, col_req : button/switch requests (one-hot row/col)
//   cell_state                   : 16 x 2-bit cell contents, cell i=4r+c
//   row_en, col_en, add_n,
//   cell_strobe                  : cell array write strobe and address
//   reject                       : refused request pulse
//   phase, shots, hits, win,
//   game_over                    : game status
// Modport master is the controller; slave is the environment side.
interface grid_game_ctrl_if #(
  parameter int CNT_W = 4
);
  logic             fire_pulse;
  logic [3:0]       row_req;
  logic [3:0]       col_req;
  logic [31:0]      cell_state;
  logic [3:0]       row_en;
  logic [3:0]       col_en;
  logic             add_n;
  logic             cell_strobe;
  logic             reject;
  logic [2:0]       phase;
  logic [CNT_W-1:0] shots;
  logic [CNT_W-1:0] hits;
  logic             win;
  logic             game_over;

  modport master (
    input  fire_pulse, row_req, col_req, cell_state,
    output row_en, col_en, add_n, cell_strobe, reject,
           phase, shots, hits, win, game_over
  );

  modport slave (
    output fire_pulse, row_req, col_req, cell_state,
    input  row_en, col_en, add_n, cell_strobe, reject,
           phase, shots, hits, win, game_over
  );
endinterface

// File: rtl/grid_game_ctrl_onehot4_to_idx.sv
// onehot4_to_idx
// Converts a 4-bit one-hot select into a 2-bit index. valid is high only
// when exactly one bit is set; idx is meaningless otherwise.
//   onehot : 4-bit request
//   idx    : encoded position
//   valid  : exactly-one-hot flag
module onehot4_to_idx (
  input  logic [3:0] onehot,
  output logic [1:0] idx,
  output logic       valid
);
  always_comb begin
    idx   = 2'd0;
    valid = 1'b0;
    case (onehot)
      4'b0001: begin idx = 2'd0; valid = 1'b1; end
      4'b0010: begin idx = 2'd1; valid = 1'b1; end
      4'b0100: begin idx = 2'd2; valid = 1'b1; end
      4'b1000: begin idx = 2'd3; valid = 1'b1; end
      default: begin idx = 2'd0; valid = 1'b0; end
    endcase
  end
endmodule

// File: rtl/grid_game_ctrl.sv
// grid_game_ctrl
// Game sequencer for a 4x4 grid of two-bit cells: place phase (ships added),
// then fire phase (shots resolved), counting shots/hits and declaring the
// result. Optional shot budget enabled by defining GAME_SHOT_LIMIT_EN.
// Ports:
//   clk   : system clock
//   reset : synchronous active-high reset (clears every output)
//   bus   : grid_game_ctrl_if.master (requests in, cell strobes/status out)
module grid_game_ctrl
  import grid_game_ctrl_pkg::*;
#(
  parameter int NUM_SHIPS = 4,
  parameter int MAX_SHOTS = 10,
  parameter int CNT_W     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  grid_game_ctrl_if.master        bus
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  logic [2:0]       phase_q;
  logic [CNT_W-1:0] ships_q, shots_q, hits_q;
  logic [3:0]       row_en_q, col_en_q, idx_q;
  logic [1:0]       cell_q;
  logic             strobe_q, reject_q, add_n_q, win_q, over_q, sampled_q;

  logic [1:0]       row_idx, col_idx;
  logic             row_vld, col_vld, sel_vld;
  logic [3:0]       sel_i;
  logic [1:0]       req_cell, lat_cell;
  logic [CNT_W-1:0] shots_nxt, hits_nxt;

  onehot4_to_idx u_row (.onehot(bus.row_req), .idx(row_idx), .valid(row_vld));
  onehot4_to_idx u_col (.onehot(bus.col_req), .idx(col_idx), .valid(col_vld));

  assign sel_vld   = row_vld && col_vld;
  assign sel_i     = {row_idx, col_idx};
  assign req_cell  = bus.cell_state[{sel_i, 1'b0} +: 2];
  assign lat_cell  = bus.cell_state[{idx_q, 1'b0} +: 2];
  assign shots_nxt = sat_inc(shots_q);
  assign hits_nxt  = (cell_q == CELL_HIT) ? sat_inc(hits_q) : hits_q;

  // CHECK spends two cycles: the first registers the updated cell, the
  // second resolves it, so counters land three edges after the fire pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q   <= PH_IDLE;
      ships_q   <= '0;
      shots_q   <= '0;
      hits_q    <= '0;
      row_en_q  <= '0;
      col_en_q  <= '0;
      idx_q     <= '0;
      cell_q    <= '0;
      strobe_q  <= 1'b0;
      reject_q  <= 1'b0;
      add_n_q   <= 1'b0;
      win_q     <= 1'b0;
      over_q    <= 1'b0;
      sampled_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      reject_q <= 1'b0;
      row_en_q <= '0;
      col_en_q <= '0;
      case (phase_q)
        PH_IDLE: begin
          add_n_q <= 1'b0;
          phase_q <= PH_PLACE;
        end
        PH_PLACE: begin
          // add_n stays low through the final placement strobe even though
          // the phase already moves to FIRE on the same edge.
          add_n_q <= 1'b0;
          if (bus.fire_pulse) begin
            if (sel_vld && req_cell == CELL_EMPTY) begin
              strobe_q <= 1'b1;
              row_en_q <= bus.row_req;
              col_en_q <= bus.col_req;
              ships_q  <= sat_inc(ships_q);
              if (int'(ships_q) + 1 == NUM_SHIPS) phase_q <= PH_FIRE;
            end else begin
              reject_q <= 1'b1;
            end
          end
        end
        PH_FIRE: begin
          add_n_q <= 1'b1;
          if (bus.fire_pulse) begin
            if (sel_vld && (req_cell == CELL_EMPTY || req_cell == CELL_SHIP)) begin
              strobe_q <= 1'b1;
              row_en_q <= bus.row_req;
              col_en_q <= bus.col_req;
              idx_q    <= sel_i;
              phase_q  <= PH_WAIT;
            end else begin
              reject_q <= 1'b1;
            end
          end
        end
        PH_WAIT: begin
          sampled_q <= 1'b0;
          phase_q   <= PH_CHECK;
        end
        PH_CHECK: begin
          if (!sampled_q) begin
            cell_q    <= lat_cell;
            sampled_q <= 1'b1;
          end else begin
            sampled_q <= 1'b0;
            shots_q   <= shots_nxt;
            hits_q    <= hits_nxt;
            if (int'(hits_nxt) == NUM_SHIPS) begin
              phase_q <= PH_DONE;
              win_q   <= 1'b1;
              over_q  <= 1'b1;
            end
`ifdef GAME_SHOT_LIMIT_EN
            else if (int'(shots_nxt) == MAX_SHOTS) begin
              phase_q <= PH_DONE;
              over_q  <= 1'b1;
            end
`endif
            else begin
              phase_q <= PH_FIRE;
            end
          end
        end
        PH_DONE: begin
          over_q <= 1'b1;
        end
        default: phase_q <= PH_IDLE;
      endcase
    end
  end

  assign bus.row_en      = row_en_q;
  assign bus.col_en      = col_en_q;
  assign bus.add_n       = add_n_q;
  assign bus.cell_strobe = strobe_q;
  assign bus.reject      = reject_q;
  assign bus.phase       = phase_q;
  assign bus.shots       = shots_q;
  assign bus.hits        = hits_q;
  assign bus.win         = win_q;
  assign bus.game_over   = over_q;

endmodule

// File: tb/tb_grid_game_ctrl.sv
// tb_grid_game_ctrl
// Bench for grid_game_ctrl with a behavioural cell array. Expected strobe and
// reject events are queued as requests are driven and compared when the
// controller emits them. Build with GAME_SHOT_LIMIT_EN to select the
// shot-limit expectations.
module tb_grid_game_ctrl;

  typedef struct packed {
    logic       rej;
    logic [3:0] r;
    logic [3:0] c;
    logic       add_n;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  ev_t  exp_q[$];
  logic [1:0] grid [16];

  always #5 clk = ~clk;

  grid_game_ctrl_if #(.CNT_W(4)) bus ();

  grid_game_ctrl #(.NUM_SHIPS(4), .MAX_SHOTS(3), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [3:0] oh(input int n);
    return 4'b0001 << n;
  endfunction

  function automatic int oh2i(input logic [3:0] v);
    int r;
    r = 0;
    for (int k = 0; k < 4; k++) if (v[k]) r = k;
    return r;
  endfunction

  // Cell array model: adds ships on add strobes, resolves shots otherwise.
  always_comb begin
    bus.cell_state = '0;
    for (int k = 0; k < 16; k++) bus.cell_state[2*k +: 2] = grid[k];
  end

  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 16; k++) grid[k] <= 2'b00;
    end else if (bus.cell_strobe) begin
      int ix;
      ix = oh2i(bus.row_en) * 4 + oh2i(bus.col_en);
      if (!bus.add_n) grid[ix] <= 2'b01;
      else            grid[ix] <= (grid[ix] == 2'b01) ? 2'b11 : 2'b10;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Output monitor: every strobe/reject must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.cell_strobe || bus.reject) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", 32'({bus.reject, bus.row_en, bus.col_en, bus.cell_strobe}), 32'd0);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check("event", 32'({bus.reject, bus.row_en, bus.col_en, bus.add_n}), 32'(e));
          check("event_strobe", 32'(bus.cell_strobe), 32'(!e.rej));
        end
      end else if (bus.row_en != 4'd0 || bus.col_en != 4'd0) begin
        check("stray_en", 32'({bus.row_en, bus.col_en}), 32'd0);
      end
    end
  end

  task automatic drive(input logic [3:0] rr, input logic [3:0] cc);
    @(posedge clk); #1;
    bus.fire_pulse = 1'b1;
    bus.row_req    = rr;
    bus.col_req    = cc;
    @(posedge clk); #1;
    bus.fire_pulse = 1'b0;
  endtask

  task automatic place_ok(input int r, input int c);
    exp_q.push_back('{rej: 1'b0, r: oh(r), c: oh(c), add_n: 1'b0});
    drive(oh(r), oh(c));
  endtask

  task automatic expect_rej(input logic [3:0] rr, input logic [3:0] cc, input logic addn);
    exp_q.push_back('{rej: 1'b1, r: 4'd0, c: 4'd0, add_n: addn});
    drive(rr, cc);
  endtask

  // Fires at an accepted cell and returns one ns after edge N+3.
  task automatic shot(input int r, input int c);
    exp_q.push_back('{rej: 1'b0, r: oh(r), c: oh(c), add_n: 1'b1});
    drive(oh(r), oh(c));
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.fire_pulse = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_phase", 32'(bus.phase), 32'd0);
    check("rst_outs", 32'({bus.row_en, bus.col_en, bus.add_n, bus.cell_strobe, bus.reject,
                           bus.shots, bus.hits, bus.win, bus.game_over}), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("phase_place", 32'(bus.phase), 32'd1);
  endtask

  task automatic place_all();
    place_ok(0, 0);
    expect_rej(oh(0), oh(0), 1'b0);
    place_ok(1, 2);
    place_ok(2, 1);
    check("still_place", 32'(bus.phase), 32'd1);
    place_ok(3, 3);
    check("phase_fire", 32'(bus.phase), 32'd2);
  endtask

  initial begin
    reset = 1'b1;
    bus.fire_pulse = 1'b0;
    bus.row_req = 4'd0;
    bus.col_req = 4'd0;

    // Game 1: placement, rejects, hit/miss, win.
    do_reset();
    place_all();

    expect_rej(4'b0011, oh(0), 1'b1);
    check("inv_phase", 32'(bus.phase), 32'd2);
    check("inv_shots", 32'(bus.shots), 32'd0);

    exp_q.push_back('{rej: 1'b0, r: oh(1), c: oh(2), add_n: 1'b1});
    drive(oh(1), oh(2));
    check("lat_wait", 32'(bus.phase), 32'd3);
    repeat (2) begin @(posedge clk); #1; end
    check("lat_check", 32'(bus.phase), 32'd4);
    check("lat_shots_old", 32'(bus.shots), 32'd0);
    @(posedge clk); #1;
    check("hit1_shots", 32'(bus.shots), 32'd1);
    check("hit1_hits", 32'(bus.hits), 32'd1);
    check("hit1_phase", 32'(bus.phase), 32'd2);

    shot(0, 1);
    check("miss_shots", 32'(bus.shots), 32'd2);
    check("miss_hits", 32'(bus.hits), 32'd1);

    expect_rej(oh(0), oh(1), 1'b1);
    check("refire_shots", 32'(bus.shots), 32'd2);

    shot(0, 0);
    shot(2, 1);
    check("hit3_hits", 32'(bus.hits), 32'd3);
    shot(3, 3);
    check("win_phase", 32'(bus.phase), 32'd5);
    check("win_flags", 32'({bus.win, bus.game_over}), 32'b11);
    check("win_counts", 32'({bus.shots, bus.hits}), 32'h54);

    drive(oh(1), oh(1));
    repeat (4) begin @(posedge clk); #1; end
    check("done_hold", 32'({bus.phase, bus.shots, bus.hits}), 32'({3'd5, 4'd5, 4'd4}));
    check("sb_empty1", 32'(exp_q.size()), 32'd0);

    // Game 2: three misses against a shot budget of three.
    do_reset();
    place_all();
    shot(0, 1);
    shot(0, 2);
    check("miss2_phase", 32'(bus.phase), 32'd2);
    shot(0, 3);
    check("limit_shots", 32'(bus.shots), 32'd3);
    check("limit_hits", 32'(bus.hits), 32'd0);
    check("limit_win", 32'(bus.win), 32'd0);
`ifdef GAME_SHOT_LIMIT_EN
    check("limit_phase", 32'(bus.phase), 32'd5);
    check("limit_over", 32'(bus.game_over), 32'd1);
`else
    check("nolimit_phase", 32'(bus.phase), 32'd2);
    check("nolimit_over", 32'(bus.game_over), 32'd0);
`endif
    repeat (3) @(posedge clk);
    #1;
    check("sb_empty2", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
